// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue stage: owns the PC, fetches from imem into the IR,
// issues decoded fields and advances the PC when the control FSM retires.
module instr_fetch_issue #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  output logic [5:0]    upcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    func,
  output logic [15:0]   imm,
  input  logic          instr_done,
  input  logic          branch_taken,
  output logic [AW-1:0] pc,
  output logic          fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [7:0]    CNT_MAX = 8'(TIMEOUT - 1);
  localparam logic [AW-1:0] PC_INC  = AW'(4);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] br_off;

  // Word-aligned, sign-extended branch displacement taken from the IR immediate.
  assign br_off = {{(AW-18){ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (run && !err_q) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = ISSUE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ISSUE: begin
        if (instr_done) begin
          pc_d    = branch_taken ? (pc_q + PC_INC + br_off) : (pc_q + PC_INC);
          state_d = run ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == ISSUE);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_err   = err_q;

  assign upcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign func   = ir_q[5:0];
  assign imm    = ir_q[15:0];

endmodule
